fft_r2_stage8: RTL and testbench
================================

// Module: fft_r2_stage8
// PURPOSE
//  Parametrised radix-2 DIF stage for the 8-point streaming FFT: one instance per stage (STAGE=0,1,2), chained.
//  Takes 8 complex lanes per frame, applies span-(4>>STAGE) butterflies, then twiddles differences by W8^k.
//  Registered valid/ready pipeline with backpressure, saturation, sticky overflow and a frame counter.
// PARAMETERS
//  W      16  signed data width per real/imag component
//  TW     16  twiddle width, signed Q1.(TW-1)
//  STAGE  0   stage index 0..2; span = 4>>STAGE, twiddle W8^(k<<STAGE)
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     asynchronous, active-low reset
//  in_valid   in   1     input frame valid
//  in_ready   out  1     stage can accept a frame
//  in_re      in   8*W   lane i real at [i*W +: W]
//  in_im      in   8*W   lane i imag, same packing
//  out_valid  out  1     output frame valid
//  out_ready  in   1     downstream accepts
//  out_re     out  8*W   lane real, same packing
//  out_im     out  8*W   lane imag
//  ovf        out  1     sticky overflow/saturation flag
//  ovf_clr    in   1     synchronous clear of ovf
//  frame_cnt  out  16    count of output transfers, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (rst=0, async): all pipeline data, valid bits, ovf, frame_cnt -> 0; out_valid=0; in_ready=1 once released.
//  Pipe enable en = out_ready | ~out_valid; in_ready = en. All 3 register stages advance only when en=1.
//  Transfers: input when in_valid&in_ready; output when out_valid&out_ready. Latency 3 cycles with no stall.
//  Bubbles are not collapsed; frame order is preserved; no frame is dropped or duplicated under stall.
//  Stage A (butterfly): for lane p with (p & span)==0, q=p+span, k=(p mod span)<<STAGE:
//    sum_p = x_p + x_q ; dif_q = x_p - x_q, computed at W+1 bits, then reduced to W (see CONFIGURATION).
//  Stage B (multiply): dif lanes x W8^k; sum lanes and k=0 pass unchanged.
//    k=2 (-j): exact swap/negate (re'=im, im'=-re), saturate to W (-2^(W-1) negated -> 2^(W-1)-1).
//    k=1,3: full complex multiply, products at W+TW+1 bits; add 2^(TW-2), arithmetic shift right TW-1, saturate to W.
//  Stage C: output register. All lanes share the same 3-stage path regardless of k.
//  Any saturation event in A or B on a transferring frame sets ovf. ovf_clr and a same-cycle set: set wins.
//  frame_cnt increments on each output transfer.
//  Reset asserted mid-stream: in-flight frames discarded, no partial frame emitted after release.
// CONFIGURATION
//  FFT_STAGE_SCALE_EN defined: stage A result arithmetic-shifted right 1 (floor); butterfly cannot saturate;
//    ovf only from stage B.
//  Undefined: stage A result saturated to W; saturation sets ovf.
// STRUCTURE
//  Package fft_pkg: TW8_RE[0:3], TW8_IM[0:3] Q1.15 constants (32767/0, 23170/-23170, 0/-32767, -23170/-23170),
//    scaled to TW; sat function (W+n -> W); lane pack/unpack macros.
//  One sub-module: fft_cmul_rnd (registered complex multiply, round, saturate, ovf out), instanced 8x.
// TESTING (W=16, TW=16)
//  STAGE=0, lane0=(1000,0), rest 0 -> after 3 cycles lane0=(1000,0), lane4=(1000,0), others 0, ovf=0.
//  STAGE=0, lane1=(1000,0) -> lane1=(1000,0), lane5=(707,-707).
//  STAGE=0, lane0=lane4=(30000,0) -> lane0=(32767,0), ovf=1. With FFT_STAGE_SCALE_EN: lane0=(30000,0), ovf=0.
//  STAGE=0, lane2=(-32768,0) -> lane6=(0,32767), ovf=1; ovf_clr pulse -> ovf=0.
//  Stream 3 frames, out_ready=0 for 5 cycles -> in_ready=0 while stalled; all 3 out in order; frame_cnt=3.
//  rst low for 1 cycle with 2 frames in flight -> out_valid=0, frame_cnt=0, ovf=0; no output until new input.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point streaming radix-2 FFT stages.
//   TW8_RE/TW8_IM : W8^k twiddles, k = 0..3, Q1.15
//   tw_scale      : rescale a Q1.15 twiddle to a Q1.(tw-1) twiddle
//   sat           : clip a signed value to a w-bit two's complement range
//   lane_is_dif   : lane carries a butterfly difference at the given stage
//   lane_k        : twiddle exponent applied to a lane at the given stage
//   FFT_LANE      : select lane i (width w) out of a packed 8-lane vector

`define FFT_LANE(vec, i, w) vec[(i)*(w) +: (w)]

package fft_pkg;

   localparam int TW8_RE [0:3] = '{32767, 23170, 0, -23170};
   localparam int TW8_IM [0:3] = '{0, -23170, -32767, -23170};

   function automatic int tw_scale(int v, int tw);
      if (tw >= 16) return v <<< (tw - 16);
      return v >>> (16 - tw);
   endfunction

   function automatic longint sat(longint v, int w);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -(longint'(1) <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic int lane_span(int stage);
      return 4 >> stage;
   endfunction

   function automatic bit lane_is_dif(int lane, int stage);
      return (lane & lane_span(stage)) != 0;
   endfunction

   // q = p + span shares p's offset inside its group, so both give the same k
   function automatic int lane_k(int lane, int stage);
      return (lane % lane_span(stage)) << stage;
   endfunction

endpackage

// File: rtl/fft_cmul_rnd.sv
// Registered multiply of one complex lane by the constant twiddle W8^K.
// Rounds half-up, shifts back to Q1.(TW-1) scaling and saturates to W bits.
//   clk, rst      : clock, asynchronous active-low reset
//   en            : pipeline advance
//   vld           : the lane being captured belongs to a real frame
//   in_re, in_im  : input lane (signed W)
//   out_re, out_im: registered result (signed W)
//   ovf           : one-cycle pulse, a saturation happened on a captured valid frame
// PASS=1 makes the lane a plain register (sum lanes and k=0 differences).

module fft_cmul_rnd
   import fft_pkg::*;
#(
   parameter int W    = 16,
   parameter int TW   = 16,
   parameter int K    = 0,
   parameter bit PASS = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         vld,
   input  logic [W-1:0] in_re,
   input  logic [W-1:0] in_im,
   output logic [W-1:0] out_re,
   output logic [W-1:0] out_im,
   output logic         ovf
);

   localparam int PW = W + TW + 1;
   localparam logic signed [TW-1:0] C   = TW'(tw_scale(TW8_RE[K], TW));
   localparam logic signed [TW-1:0] D   = TW'(tw_scale(TW8_IM[K], TW));
   localparam logic signed [PW-1:0] RND = PW'(1) <<< (TW - 2);

   logic signed [W-1:0]  a, b;
   logic signed [W:0]    neg;
   logic signed [PW-1:0] pr, pi;
   longint               sr, si, cr, ci, nr, nc;
   logic [W-1:0]         re_d, im_d;
   logic                 sat_d;

   always_comb begin
      a  = $signed(in_re);
      b  = $signed(in_im);
      neg = -((W+1)'(a));
      pr = PW'(a) * PW'(C) - PW'(b) * PW'(D) + RND;
      pi = PW'(a) * PW'(D) + PW'(b) * PW'(C) + RND;
      sr = longint'(pr >>> (TW - 1));
      si = longint'(pi >>> (TW - 1));
      cr = sat(sr, W);
      ci = sat(si, W);
      nr = longint'(neg);
      nc = sat(nr, W);
      re_d  = in_re;
      im_d  = in_im;
      sat_d = 1'b0;
      if (!PASS) begin
         if (K == 2) begin
            // -j is exact: swap and negate, only -2^(W-1) can overflow
            re_d  = in_im;
            im_d  = W'(nc);
            sat_d = (nc != nr);
         end else begin
            re_d  = W'(cr);
            im_d  = W'(ci);
            sat_d = (cr != sr) || (ci != si);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_re <= '0;
         out_im <= '0;
         ovf    <= 1'b0;
      end else begin
         // pulse only at capture so a stalled frame is never counted twice
         ovf <= en & vld & sat_d;
         if (en) begin
            out_re <= re_d;
            out_im <= im_d;
         end
      end
   end

endmodule

// File: rtl/fft_r2_stage8.sv
// One radix-2 decimation-in-frequency stage of the 8-point streaming FFT.
// Three register stages: A butterfly, B twiddle multiply, C output.
//   clk, rst             : clock, asynchronous active-low reset
//   in_valid, in_ready   : input frame handshake
//   in_re, in_im         : 8 lanes, lane i at [i*W +: W]
//   out_valid, out_ready : output frame handshake
//   out_re, out_im       : 8 lanes, same packing
//   ovf, ovf_clr         : sticky saturation flag and its synchronous clear
//   frame_cnt            : output transfer count, wraps
// Build option FFT_STAGE_SCALE_EN: halve the butterfly result instead of
// saturating it, so only the multiply stage can raise ovf.

module fft_r2_stage8
   import fft_pkg::*;
#(
   parameter int W     = 16,
   parameter int TW    = 16,
   parameter int STAGE = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [8*W-1:0] in_re,
   input  logic [8*W-1:0] in_im,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [8*W-1:0] out_re,
   output logic [8*W-1:0] out_im,
   output logic           ovf,
   input  logic           ovf_clr,
   output logic [15:0]    frame_cnt
);

   localparam int SPAN = 4 >> STAGE;

   logic           en;
   logic [8*W-1:0] a_re_d, a_im_d, a_re_q, a_im_q;
   logic [8*W-1:0] b_re, b_im, c_re_q, c_im_q;
   logic [7:0]     a_sat, b_ovf;
   logic           a_valid_q, b_valid_q, c_valid_q;
   logic           ovf_set;

   // whole pipe moves together; a bubble in C never blocks the input
   assign en        = out_ready | ~out_valid;
   assign in_ready  = en;
   assign out_valid = c_valid_q;
   assign out_re    = c_re_q;
   assign out_im    = c_im_q;

   for (genvar i = 0; i < 8; i++) begin : g_lane
      localparam bit DIF = lane_is_dif(i, STAGE);
      localparam int K   = lane_k(i, STAGE);
      localparam int P   = DIF ? i - SPAN : i;
      localparam int Q   = DIF ? i : i + SPAN;

      logic signed [W:0] p_re, p_im, q_re, q_im, f_re, f_im;

      always_comb begin
         p_re = (W+1)'($signed(`FFT_LANE(in_re, P, W)));
         p_im = (W+1)'($signed(`FFT_LANE(in_im, P, W)));
         q_re = (W+1)'($signed(`FFT_LANE(in_re, Q, W)));
         q_im = (W+1)'($signed(`FFT_LANE(in_im, Q, W)));
         if (DIF) begin
            f_re = p_re - q_re;
            f_im = p_im - q_im;
         end else begin
            f_re = p_re + q_re;
            f_im = p_im + q_im;
         end
      end

`ifdef FFT_STAGE_SCALE_EN
      assign `FFT_LANE(a_re_d, i, W) = W'(f_re >>> 1);
      assign `FFT_LANE(a_im_d, i, W) = W'(f_im >>> 1);
      assign a_sat[i] = 1'b0;
`else
      assign `FFT_LANE(a_re_d, i, W) = W'(sat(longint'(f_re), W));
      assign `FFT_LANE(a_im_d, i, W) = W'(sat(longint'(f_im), W));
      assign a_sat[i] = (sat(longint'(f_re), W) != longint'(f_re)) ||
                        (sat(longint'(f_im), W) != longint'(f_im));
`endif

      fft_cmul_rnd #(
         .W   (W),
         .TW  (TW),
         .K   (K),
         .PASS(!DIF || K == 0)
      ) u_cmul (
         .clk   (clk),
         .rst   (rst),
         .en    (en),
         .vld   (a_valid_q),
         .in_re (`FFT_LANE(a_re_q, i, W)),
         .in_im (`FFT_LANE(a_im_q, i, W)),
         .out_re(`FFT_LANE(b_re, i, W)),
         .out_im(`FFT_LANE(b_im, i, W)),
         .ovf   (b_ovf[i])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_valid_q <= 1'b0;
         b_valid_q <= 1'b0;
         c_valid_q <= 1'b0;
         a_re_q    <= '0;
         a_im_q    <= '0;
         c_re_q    <= '0;
         c_im_q    <= '0;
      end else if (en) begin
         a_valid_q <= in_valid;
         a_re_q    <= a_re_d;
         a_im_q    <= a_im_d;
         b_valid_q <= a_valid_q;
         c_valid_q <= b_valid_q;
         c_re_q    <= b_re;
         c_im_q    <= b_im;
      end
   end

   assign ovf_set = (en & in_valid & (|a_sat)) | (|b_ovf);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf       <= 1'b0;
         frame_cnt <= '0;
      end else begin
         ovf <= ovf_set | (ovf & ~ovf_clr);
         if (out_valid && out_ready) frame_cnt <= frame_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_fft_r2_stage8.sv
module tb_fft_r2_stage8;

   localparam int W  = 16;
   localparam int TW = 16;
   localparam int NV = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [8*W-1:0] in_re = '0;
   logic [8*W-1:0] in_im = '0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [8*W-1:0] out_re, out_im;
   logic           ovf;
   logic           ovf_clr = 1'b0;
   logic [15:0]    frame_cnt;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   fft_r2_stage8 #(.W(W), .TW(TW), .STAGE(0)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_re    (in_re),
      .in_im    (in_im),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_re   (out_re),
      .out_im   (out_im),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr),
      .frame_cnt(frame_cnt)
   );

   typedef struct packed {
      logic [7:0][15:0] in_re;
      logic [7:0][15:0] in_im;
      logic [7:0][15:0] ex_re;
      logic [7:0][15:0] ex_im;
      logic             ex_ovf;
   } vec_t;

   vec_t vecs [NV];

   task automatic check(input string name, input int act, input int exp);
      n_run++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic set_in(input int n, input int l, input int re, input int im);
      vecs[n].in_re[l] = 16'(re);
      vecs[n].in_im[l] = 16'(im);
   endtask

   task automatic set_ex(input int n, input int l, input int re, input int im);
      vecs[n].ex_re[l] = 16'(re);
      vecs[n].ex_im[l] = 16'(im);
   endtask

   // frame input captured at the next rising edge; return extra negedges until out_valid
   task automatic send_and_wait(input logic [8*W-1:0] re, input logic [8*W-1:0] im,
                                output int lat);
      @(negedge clk);
      in_re    = re;
      in_im    = im;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int lat;
      int got;
      int seen [3];
      int cnt;

      for (int n = 0; n < NV; n++) vecs[n] = '0;
`ifdef FFT_STAGE_SCALE_EN
      set_in(0, 0, 1000, 0);    set_ex(0, 0, 500, 0);     set_ex(0, 4, 500, 0);
      set_in(1, 1, 1000, 0);    set_ex(1, 1, 500, 0);     set_ex(1, 5, 354, -354);
      set_in(2, 0, 30000, 0);   set_in(2, 4, 30000, 0);   set_ex(2, 0, 30000, 0);
      set_in(3, 2, -32768, 0);  set_ex(3, 2, -16384, 0);  set_ex(3, 6, 0, 16384);
      set_in(4, 3, 0, 1000);    set_ex(4, 3, 0, 500);     set_ex(4, 7, 354, -354);
      set_in(5, 2, 100, 200);   set_in(5, 6, 30, -50);
      set_ex(5, 2, 65, 75);     set_ex(5, 6, 125, -35);
      set_in(6, 1, -1000, 2000); set_ex(6, 1, -500, 1000); set_ex(6, 5, 354, 1061);
      set_in(7, 0, -30000, -30000); set_in(7, 4, -30000, -30000);
      set_ex(7, 0, -30000, -30000);
`else
      set_in(0, 0, 1000, 0);    set_ex(0, 0, 1000, 0);    set_ex(0, 4, 1000, 0);
      set_in(1, 1, 1000, 0);    set_ex(1, 1, 1000, 0);    set_ex(1, 5, 707, -707);
      set_in(2, 0, 30000, 0);   set_in(2, 4, 30000, 0);   set_ex(2, 0, 32767, 0);
      vecs[2].ex_ovf = 1'b1;
      set_in(3, 2, -32768, 0);  set_ex(3, 2, -32768, 0);  set_ex(3, 6, 0, 32767);
      vecs[3].ex_ovf = 1'b1;
      set_in(4, 3, 0, 1000);    set_ex(4, 3, 0, 1000);    set_ex(4, 7, 707, -707);
      set_in(5, 2, 100, 200);   set_in(5, 6, 30, -50);
      set_ex(5, 2, 130, 150);   set_ex(5, 6, 250, -70);
      set_in(6, 1, -1000, 2000); set_ex(6, 1, -1000, 2000); set_ex(6, 5, 707, 2121);
      set_in(7, 0, -30000, -30000); set_in(7, 4, -30000, -30000);
      set_ex(7, 0, -32768, -32768);
      vecs[7].ex_ovf = 1'b1;
`endif

      // reset state
      @(negedge clk);
      @(negedge clk);
      check("reset out_valid", int'(out_valid), 0);
      check("reset ovf", int'(ovf), 0);
      check("reset frame_cnt", int'(frame_cnt), 0);
      rst = 1'b1;
      @(negedge clk);
      check("reset in_ready", int'(in_ready), 1);

      // directed vectors
      for (int n = 0; n < NV; n++) begin
         send_and_wait(vecs[n].in_re, vecs[n].in_im, lat);
         check($sformatf("v%0d latency", n), lat, 2);
         for (int l = 0; l < 8; l++) begin
            check($sformatf("v%0d lane%0d re", n, l), int'($signed(out_re[l*W +: W])),
                  int'($signed(vecs[n].ex_re[l])));
            check($sformatf("v%0d lane%0d im", n, l), int'($signed(out_im[l*W +: W])),
                  int'($signed(vecs[n].ex_im[l])));
         end
         check($sformatf("v%0d ovf", n), int'(ovf), int'(vecs[n].ex_ovf));
         ovf_clr = 1'b1;
         @(negedge clk);
         ovf_clr = 1'b0;
         check($sformatf("v%0d ovf after clr", n), int'(ovf), 0);
      end
      check("frame_cnt after vectors", int'(frame_cnt), NV);

      // three frames into a stalled output
      do_reset();
      out_ready = 1'b0;
      for (int f = 1; f <= 3; f++) begin
         @(negedge clk);
         check($sformatf("stall fill%0d in_ready", f), int'(in_ready), 1);
         in_re = '0;
         in_im = '0;
         in_re[W-1:0] = 16'(f);
         in_valid = 1'b1;
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         check($sformatf("stall c%0d in_ready", c), int'(in_ready), 0);
         check($sformatf("stall c%0d out_valid", c), int'(out_valid), 1);
      end
      out_ready = 1'b1;
      got = 0;
      for (int c = 0; c < 20 && got < 3; c++) begin
         if (out_valid) begin
            seen[got] = int'($signed(out_re[W-1:0]));
            got++;
         end
         @(negedge clk);
      end
      check("stall frames out", got, 3);
      for (int f = 0; f < 3; f++) begin
         check($sformatf("stall order%0d", f), (f < got) ? seen[f] : -1, f + 1);
      end
      check("stall frame_cnt", int'(frame_cnt), 3);

      // reset with two frames in flight
      @(negedge clk);
      in_re = '0;
      in_im = '0;
      in_re[W-1:0] = 16'd30000;
      in_re[4*W +: W] = 16'd30000;
      in_valid = 1'b1;
      @(negedge clk);
      in_re[W-1:0] = 16'd5;
      in_re[4*W +: W] = 16'd0;
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("midrst out_valid", int'(out_valid), 0);
      check("midrst frame_cnt", int'(frame_cnt), 0);
      check("midrst ovf", int'(ovf), 0);
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check("midrst stray outputs", cnt, 0);
      in_re = '0;
      in_re[W-1:0] = 16'd7;
      send_and_wait(in_re, '0, lat);
      check("postrst latency", lat, 2);
      check("postrst lane0", int'($signed(out_re[W-1:0])), 7);
      check("postrst lane4", int'($signed(out_re[4*W +: W])), 7);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
